id_ex_stage: RTL and testbench

ID/EX pipeline stage that sits directly downstream of the register file. Each rising edge it latches the decoded instruction fields, the sign-extended immediate and the two register read values into EX-facing registers. It also detects load-use hazards, stalling the upstream IF/ID stage and inserting a bubble. A write-back bypass covers a same-cycle write to a register that is being read.

---
 rtl/id_ex_stage.sv | 96 +++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and write-back bypass; ID_EX_PERF_CTR_EN adds StallCount/FlushCount
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [31:0]        Instr,
  input  logic               IdValid,
  input  logic [DATA_W-1:0]  RD1,
  input  logic [DATA_W-1:0]  RD2,
  input  logic               RegWrite_in,
  input  logic               MemRead_in,
  input  logic               MemWrite_in,
  input  logic               MemToReg_in,
  input  logic               ALUSrc_in,
  input  logic               RegDst_in,
  input  logic [ALUOP_W-1:0] ALUOp_in,
  input  logic               WbWrite,
  input  logic [REG_AW-1:0]  WbWR,
  input  logic [DATA_W-1:0]  WbWD,
  input  logic               Flush,
  output logic               Stall,
  output logic               ExValid,
  output logic               ExRegWrite,
  output logic               ExMemRead,
  output logic               ExMemWrite,
  output logic               ExMemToReg,
  output logic               ExALUSrc,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic [DATA_W-1:0]  ExA,
  output logic [DATA_W-1:0]  ExB,
  output logic [DATA_W-1:0]  ExImm,
  output logic [REG_AW-1:0]  ExRs,
  output logic [REG_AW-1:0]  ExRt,
`ifdef ID_EX_PERF_CTR_EN
  output logic [31:0]        StallCount,
  output logic [31:0]        FlushCount,
`endif
  output logic [REG_AW-1:0]  ExDst
);
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] a, b;
  logic bubble;
  // rs/rt nonzero implies WbWR nonzero on a match, so $0 never picks up a bypass
  always_comb begin
    rs = Instr[25:21];
    rt = Instr[20:16];
    rd = Instr[15:11];
    a = rs == '0 ? '0 : (WbWrite && WbWR == rs) ? WbWD : RD1;
    b = rt == '0 ? '0 : (WbWrite && WbWR == rt) ? WbWD : RD2;
    Stall = IdValid && ExValid && ExMemRead && ExRt != '0 && (ExRt == rs || ExRt == rt);
    bubble = Flush || Stall || !IdValid;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      ExValid    <= 1'b0;
      ExRegWrite <= 1'b0;
      ExMemRead  <= 1'b0;
      ExMemWrite <= 1'b0;
      ExMemToReg <= 1'b0;
      ExALUSrc   <= 1'b0;
      ExALUOp    <= '0;
      ExA        <= '0;
      ExB        <= '0;
      ExImm      <= '0;
      ExRs       <= '0;
      ExRt       <= '0;
      ExDst      <= '0;
    end else begin
      ExValid    <= !bubble;
      ExRegWrite <= RegWrite_in && !bubble;
      ExMemRead  <= MemRead_in && !bubble;
      ExMemWrite <= MemWrite_in && !bubble;
      ExMemToReg <= MemToReg_in && !bubble;
      ExALUSrc   <= ALUSrc_in && !bubble;
      ExALUOp    <= bubble ? '0 : ALUOp_in;
      ExA        <= a;
      ExB        <= b;
      ExImm      <= {{(DATA_W-16){Instr[15]}}, Instr[15:0]};
      ExRs       <= rs;
      ExRt       <= rt;
      ExDst      <= RegDst_in ? rd : rt;
    end
`ifdef ID_EX_PERF_CTR_EN
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (Stall && !Flush && ~&StallCount) StallCount <= StallCount + 32'd1;
      if (Flush && ~&FlushCount) FlushCount <= FlushCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  logic Clk = 0, Reset;
  logic [31:0] Instr;
  logic IdValid;
  logic [31:0] RD1, RD2, WbWD;
  logic RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, RegDst_in;
  logic [3:0] ALUOp_in;
  logic WbWrite, Flush;
  logic [4:0] WbWR;
  logic Stall, ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc;
  logic [3:0] ExALUOp;
  logic [31:0] ExA, ExB, ExImm;
  logic [4:0] ExRs, ExRt, ExDst;
`ifdef ID_EX_PERF_CTR_EN
  logic [31:0] StallCount, FlushCount;
`endif

  id_ex_stage dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .IdValid(IdValid), .RD1(RD1), .RD2(RD2),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .RegDst_in(RegDst_in), .ALUOp_in(ALUOp_in),
    .WbWrite(WbWrite), .WbWR(WbWR), .WbWD(WbWD), .Flush(Flush), .Stall(Stall), .ExValid(ExValid),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExMemToReg(ExMemToReg), .ExALUSrc(ExALUSrc), .ExALUOp(ExALUOp), .ExA(ExA), .ExB(ExB),
    .ExImm(ExImm), .ExRs(ExRs), .ExRt(ExRt),
`ifdef ID_EX_PERF_CTR_EN
    .StallCount(StallCount), .FlushCount(FlushCount),
`endif
    .ExDst(ExDst)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic valid;
    logic [8:0] ctl;
    logic [31:0] a, b, imm;
    logic [4:0] dst;
  } exp_t;
  typedef struct {
    logic [31:0] instr;
    logic idv;
    logic [9:0] ctl;
    logic [31:0] rd1, rd2;
    logic wbw;
    logic [4:0] wbwr;
    logic [31:0] wbwd;
    logic flush, estall;
    exp_t e;
  } vec_t;

  localparam logic [9:0] CR = 10'b1000010010;
  localparam logic [9:0] CL = 10'b1101100000;
  localparam logic [9:0] CI = 10'b1000100011;
  localparam logic [8:0] ER = 9'b100000010;
  localparam logic [8:0] EL = 9'b110110000;
  localparam logic [8:0] EI = 9'b100010011;
  localparam logic [8:0] E0 = 9'b0;

  int nvec = 0, nerr = 0;
  vec_t tbl[$];
  exp_t sb[$];

  function automatic logic [31:0] R(logic [4:0] s, logic [4:0] t, logic [4:0] d);
    return {6'h00, s, t, d, 11'h000};
  endfunction
  function automatic logic [31:0] I(logic [4:0] s, logic [4:0] t, logic [15:0] imm);
    return {6'h23, s, t, imm};
  endfunction
  function automatic vec_t v(logic [31:0] instr, logic idv, logic [9:0] ctl, logic [31:0] rd1, rd2,
                             logic wbw, logic [4:0] wbwr, logic [31:0] wbwd, logic flush, estall,
                             logic evalid, logic [8:0] ectl, logic [31:0] ea, eb, eimm, logic [4:0] edst);
    vec_t r;
    r.instr = instr; r.idv = idv; r.ctl = ctl; r.rd1 = rd1; r.rd2 = rd2;
    r.wbw = wbw; r.wbwr = wbwr; r.wbwd = wbwd; r.flush = flush; r.estall = estall;
    r.e.valid = evalid; r.e.ctl = ectl; r.e.a = ea; r.e.b = eb; r.e.imm = eimm; r.e.dst = edst;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    Instr = x.instr; IdValid = x.idv;
    {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, RegDst_in, ALUOp_in} = x.ctl;
    RD1 = x.rd1; RD2 = x.rd2; WbWrite = x.wbw; WbWR = x.wbwr; WbWD = x.wbwd; Flush = x.flush;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, ExValid}, 0);
    chk({tag, "_ctl"}, {23'b0, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExALUOp}, 0);
    chk({tag, "_ab"}, ExA | ExB, 0);
    chk({tag, "_imm"}, ExImm, 0);
    chk({tag, "_regs"}, {17'b0, ExRs, ExRt, ExDst}, 0);
    chk({tag, "_stall"}, {31'b0, Stall}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t x;
    int esc = 0, efc = 0;
    tbl.push_back(v(R(1,2,3),1,CR,5,7,0,0,0,0, 0,1,ER,5,7,32'h1800,3));
    tbl.push_back(v(I(1,4,16'h8),1,CL,32'h100,32'h55,0,0,0,0, 0,1,EL,32'h100,32'h55,8,4));
    tbl.push_back(v(R(4,2,5),1,CR,9,7,0,0,0,0, 1,0,E0,0,0,0,0));
    tbl.push_back(v(R(4,2,5),1,CR,9,7,0,0,0,0, 0,1,ER,9,7,32'h2800,5));
    tbl.push_back(v(R(1,2,6),1,CR,1,32'h11,1,2,32'hDEADBEEF,0, 0,1,ER,1,32'hDEADBEEF,32'h3000,6));
    tbl.push_back(v(R(1,2,6),1,CR,1,32'h11,1,0,32'hDEADBEEF,0, 0,1,ER,1,32'h11,32'h3000,6));
    tbl.push_back(v(R(0,0,7),1,CR,32'hAA,32'hBB,1,0,32'h123,0, 0,1,ER,0,0,32'h3800,7));
    tbl.push_back(v(R(9,0,8),1,CR,1,32'hBB,1,9,32'hCAFE,0, 0,1,ER,32'hCAFE,0,32'h4000,8));
    tbl.push_back(v(I(1,10,16'h8000),1,CL,3,4,0,0,0,0, 0,1,EL,3,4,32'hFFFF8000,10));
    tbl.push_back(v(R(10,0,11),1,CR,1,2,0,0,0,1, 1,0,E0,0,0,0,0));
    tbl.push_back(v(I(0,12,16'h7FFF),1,CL,32'h77,32'h66,0,0,0,0, 0,1,EL,0,32'h66,32'h7FFF,12));
    tbl.push_back(v(R(12,0,13),0,CR,1,2,0,0,0,0, 0,0,E0,0,0,0,0));
    tbl.push_back(v(I(1,13,0),1,CL,5,6,0,0,0,0, 0,1,EL,5,6,0,13));
    tbl.push_back(v(I(2,14,4),1,CL,7,8,0,0,0,0, 0,1,EL,7,8,4,14));
    tbl.push_back(v(R(13,0,15),1,CR,1,2,0,0,0,0, 0,1,ER,1,0,32'h7800,15));
    tbl.push_back(v(I(1,0,0),1,CL,5,6,0,0,0,0, 0,1,EL,5,0,0,0));
    tbl.push_back(v(R(0,0,1),1,CR,5,6,0,0,0,0, 0,1,ER,0,0,32'h0800,1));
    tbl.push_back(v(I(1,2,0),1,CL,5,6,0,0,0,0, 0,1,EL,5,6,0,2));
    tbl.push_back(v(I(5,2,16'h10),1,CI,3,4,0,0,0,0, 1,0,E0,0,0,0,0));
    tbl.push_back(v(I(5,2,16'h10),1,CI,3,4,0,0,0,0, 0,1,EI,3,4,32'h10,2));
    tbl.push_back(v(R(1,2,3),1,CR,5,7,0,0,0,1, 0,0,E0,0,0,0,0));

    Reset = 1;
    drive(v(0,0,0,0,0,0,0,0,0, 0,0,E0,0,0,0,0));
    #12;
    chk_zero("reset");
    @(negedge Clk);
    Reset = 0;

    foreach (tbl[i]) begin
      @(negedge Clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("stall[%0d]", i), {31'b0, Stall}, {31'b0, tbl[i].estall});
      sb.push_back(tbl[i].e);
      if (tbl[i].estall && !tbl[i].flush) esc++;
      if (tbl[i].flush) efc++;
      @(posedge Clk);
      #1;
      x = sb.pop_front();
      chk($sformatf("valid[%0d]", i), {31'b0, ExValid}, {31'b0, x.valid});
      chk($sformatf("ctl[%0d]", i),
          {23'b0, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExALUOp}, {23'b0, x.ctl});
      if (x.valid) begin
        chk($sformatf("a[%0d]", i), ExA, x.a);
        chk($sformatf("b[%0d]", i), ExB, x.b);
        chk($sformatf("imm[%0d]", i), ExImm, x.imm);
        chk($sformatf("dst[%0d]", i), {27'b0, ExDst}, {27'b0, x.dst});
      end
    end
`ifdef ID_EX_PERF_CTR_EN
    chk("stall_count", StallCount, esc);
    chk("flush_count", FlushCount, efc);
`endif

    // reset arriving mid-stall: everything clears before the next edge
    @(negedge Clk);
    drive(v(I(1,4,16'h8),1,CL,1,2,0,0,0,0, 0,0,E0,0,0,0,0));
    @(posedge Clk);
    #1;
    chk("ld_rs", {27'b0, ExRs}, 1);
    chk("ld_rt", {27'b0, ExRt}, 4);
    @(negedge Clk);
    drive(v(R(4,2,5),1,CR,9,7,0,0,0,0, 0,0,E0,0,0,0,0));
    #1;
    chk("pre_reset_stall", {31'b0, Stall}, 1);
    Reset = 1;
    #1;
    chk_zero("midreset");
`ifdef ID_EX_PERF_CTR_EN
    chk("reset_counts", StallCount | FlushCount, 0);
`endif
    @(negedge Clk);
    Reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
